mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequencer and arbiter for the single-ported main memory shared by the I-cache and D-cache. It accepts block-fill requests from both caches and word write-through requests from the D-cache. It grants one requester at a time, drives the main-memory address, enable and write lines, and counts returned words. It steers each returned word into the granted cache's data array with a word index, and pulses a per-cache fill-done that the cache uses to write its tag array.

## Interface
- BLOCK_WORDS, 8, 16-bit words per cache block; power of 2; offset field = log2(BLOCK_WORDS)+1 address bits (byte-addressed, word-aligned).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- i_miss  in  1  I-cache miss request (level).
- i_miss_addr  in  16  I-cache missed address.
- d_miss  in  1  D-cache miss request (level).
- d_miss_addr  in  16  D-cache missed address.
- d_wr_req  in  1  D-cache store write-through request (level).
- d_wr_addr  in  16  store address.
- d_wr_data  in  16  store data.
- mem_addr  out  16  main-memory address.
- mem_data_in  out  16  main-memory write data.
- mem_enable  out  1  main-memory access enable.
- mem_wr  out  1  main-memory write.
- mem_data_out  in  16  main-memory read data.
- mem_data_valid  in  1  read data valid.
- fill_data  out  16  word to write into the cache (= mem_data_out).
- fill_word  out  log2(BLOCK_WORDS)  word index within the block.
- i_fill_we / d_fill_we  out  1  data-array write strobe for each cache.
- i_fill_done / d_fill_done  out  1  one-cycle pulse on the last word; the cache writes its tag array.
- i_busy / d_busy  out  1  requester currently granted.
- wr_ack  out  1  one-cycle pulse; the store has been written to memory.

## Operation
- States: IDLE, I_FILL, D_FILL, WRITE. Reset → IDLE; all outputs 0; counters 0.
- In IDLE, at the edge, the arbiter grants with fixed priority: i_miss → I_FILL; else d_wr_req → WRITE; else d_miss → D_FILL. It latches the block base of the granted address (offset bits cleared) or the store address/data.
- Fill states:
  - Issue counter iss (0..BLOCK_WORDS) and receive counter rcv are cleared on entry.
  - While iss < BLOCK_WORDS: mem_enable=1, mem_wr=0, mem_addr = base | (iss<<1); iss increments each cycle.
  - Each mem_data_valid asserts the granted cache's *_fill_we, with fill_word=rcv; then rcv increments.
  - When mem_data_valid and rcv==BLOCK_WORDS-1, the arbiter also pulses *_fill_done and goes to IDLE.
- WRITE (one cycle): mem_enable=1, mem_wr=1, mem_addr/mem_data_in = latched store, wr_ack=1; then IDLE.
- mem_data_in=0 and mem_wr=0 outside WRITE. mem_enable=0 in IDLE and after issue completes.
- i_busy=1 throughout I_FILL; d_busy=1 throughout D_FILL and WRITE.
- Requests are sampled only in IDLE. A request dropped mid-operation is ignored and the fill completes. Requesters must drop their miss in the cycle after *_fill_done, because the tag hit makes it so.
- mem_data_valid in IDLE or WRITE is ignored: no strobes.
- rst mid-operation → IDLE next edge, counters cleared, no done/ack pulse.

## Timing
- Grant latency: 1 cycle (request seen in IDLE at edge N; first issue cycle N+1).
- Fill: BLOCK_WORDS consecutive issue cycles. Completion is set by memory latency L: done in the cycle of the last valid, i.e. issue start + BLOCK_WORDS−1+L. For L=4, BLOCK_WORDS=8, done occurs 11 cycles after the first issue.
- At least one IDLE cycle separates operations. Store: request to wr_ack = 2 cycles.
- Simultaneous i_miss, d_wr_req and d_miss in IDLE: I fill first, then store, then D fill.

## Test plan
- Reset, then i_miss with i_miss_addr=0x1236 → mem_addr 0x1230,0x1232..0x123E on 8 consecutive cycles. i_fill_we with fill_word 0..7 follows each valid. i_fill_done is high with word 7; d outputs stay 0.
- i_miss, d_miss (0x4000) and d_wr_req (0x2002, 0xBEEF) in the same cycle → I fill completes, then WRITE with mem_wr=1, addr 0x2002, data 0xBEEF, and wr_ack. Then the D fill runs on 0x4000..0x400E with d_fill_done.
- D fill in progress; i_miss rises at word 3 → the D fill finishes uninterrupted, and the I fill is granted in the IDLE cycle after d_fill_done.
- rst asserted at issue cycle 5 of an I fill → the next cycle is IDLE with all outputs 0. Late mem_data_valid pulses produce no fill_we or done.
- Stray mem_data_valid in IDLE → no strobes. Requester drops i_miss mid-fill → all 8 words and i_fill_done are still produced.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the cache arbiter, the two caches and main memory.
// The master modport is the arbiter side; the slave modport is the cache/memory side.
interface mem_arbiter_if #(
  parameter int BLOCK_WORDS = 8
);
  localparam int WW = $clog2(BLOCK_WORDS);

  // Handshake: i_miss, d_miss and d_wr_req are levels held by the cache until
  // the matching *_fill_done / wr_ack pulse; mem_data_valid qualifies one word
  // of mem_data_out in its cycle; there is no back-pressure on either side.
  logic          i_miss;
  logic [15:0]   i_miss_addr;
  logic          d_miss;
  logic [15:0]   d_miss_addr;
  logic          d_wr_req;
  logic [15:0]   d_wr_addr;
  logic [15:0]   d_wr_data;
  logic [15:0]   mem_addr;
  logic [15:0]   mem_data_in;
  logic          mem_enable;
  logic          mem_wr;
  logic [15:0]   mem_data_out;
  logic          mem_data_valid;
  logic [15:0]   fill_data;
  logic [WW-1:0] fill_word;
  logic          i_fill_we;
  logic          d_fill_we;
  logic          i_fill_done;
  logic          d_fill_done;
  logic          i_busy;
  logic          d_busy;
  logic          wr_ack;

  modport master (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr,
    input  d_wr_req, d_wr_addr, d_wr_data,
    input  mem_data_out, mem_data_valid,
    output mem_addr, mem_data_in, mem_enable, mem_wr,
    output fill_data, fill_word, i_fill_we, d_fill_we,
    output i_fill_done, d_fill_done, i_busy, d_busy, wr_ack
  );

  modport slave (
    output i_miss, i_miss_addr, d_miss, d_miss_addr,
    output d_wr_req, d_wr_addr, d_wr_data,
    output mem_data_out, mem_data_valid,
    input  mem_addr, mem_data_in, mem_enable, mem_wr,
    input  fill_data, fill_word, i_fill_we, d_fill_we,
    input  i_fill_done, d_fill_done, i_busy, d_busy, wr_ack
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter and block-fill sequencer for the single-ported main
// memory shared by the I-cache (fills) and D-cache (fills and write-through).
module mem_arbiter #(
  parameter int BLOCK_WORDS = 8
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus,
  output logic [1:0]    state_dbg
);
  localparam int WW = $clog2(BLOCK_WORDS);
  localparam int CW = WW + 1;
  localparam logic [15:0]   OFFSET_MASK = 16'((2 * BLOCK_WORDS) - 1);
  localparam logic [CW-1:0] ISS_END     = CW'(BLOCK_WORDS);
  localparam logic [WW-1:0] LAST_WORD   = WW'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_FILL = 2'd1,
    D_FILL = 2'd2,
    WRITE  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] iss;
  logic [WW-1:0] rcv;
  logic [15:0]   lat_addr;
  logic [15:0]   lat_data;
  logic          filling;
  logic          issuing;
  logic          last_beat;

  assign filling   = (state == I_FILL) || (state == D_FILL);
  assign issuing   = filling && (iss < ISS_END);
  assign last_beat = filling && bus.mem_data_valid && (rcv == LAST_WORD);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.i_miss)        state_nx = I_FILL;
        else if (bus.d_wr_req) state_nx = WRITE;
        else if (bus.d_miss)   state_nx = D_FILL;
      end
      I_FILL, D_FILL: if (last_beat) state_nx = IDLE;
      WRITE:          state_nx = IDLE;
      default:        state_nx = IDLE;
    endcase
  end

  // Counters are held at zero while idle so every fill starts from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss      <= '0;
      rcv      <= '0;
      lat_addr <= '0;
      lat_data <= '0;
    end else if (state == IDLE) begin
      iss <= '0;
      rcv <= '0;
      if (bus.i_miss) begin
        lat_addr <= bus.i_miss_addr & ~OFFSET_MASK;
      end else if (bus.d_wr_req) begin
        lat_addr <= bus.d_wr_addr;
        lat_data <= bus.d_wr_data;
      end else if (bus.d_miss) begin
        lat_addr <= bus.d_miss_addr & ~OFFSET_MASK;
      end
    end else if (filling) begin
      if (issuing)            iss <= iss + 1'b1;
      if (bus.mem_data_valid) rcv <= rcv + 1'b1;
    end
  end

  always_comb begin
    bus.mem_addr    = '0;
    bus.mem_data_in = '0;
    bus.mem_enable  = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.fill_data   = bus.mem_data_out;
    bus.fill_word   = '0;
    bus.i_fill_we   = 1'b0;
    bus.d_fill_we   = 1'b0;
    bus.i_fill_done = 1'b0;
    bus.d_fill_done = 1'b0;
    bus.i_busy      = 1'b0;
    bus.d_busy      = 1'b0;
    bus.wr_ack      = 1'b0;
    case (state)
      I_FILL, D_FILL: begin
        bus.mem_enable = issuing;
        if (issuing) bus.mem_addr = lat_addr | (16'(iss) << 1);
        bus.fill_word   = rcv;
        bus.i_fill_we   = (state == I_FILL) && bus.mem_data_valid;
        bus.d_fill_we   = (state == D_FILL) && bus.mem_data_valid;
        bus.i_fill_done = (state == I_FILL) && last_beat;
        bus.d_fill_done = (state == D_FILL) && last_beat;
        bus.i_busy      = (state == I_FILL);
        bus.d_busy      = (state == D_FILL);
      end
      WRITE: begin
        bus.mem_enable  = 1'b1;
        bus.mem_wr      = 1'b1;
        bus.mem_addr    = lat_addr;
        bus.mem_data_in = lat_data;
        bus.d_busy      = 1'b1;
        bus.wr_ack      = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, checked every
// cycle against a transaction-level model with a latency-L memory.
module tb_mem_arbiter;
  localparam int BW = 8;
  localparam logic [15:0] MASK = 16'hFFF0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;

  mem_arbiter_if #(.BLOCK_WORDS(BW)) bus ();
  mem_arbiter #(.BLOCK_WORDS(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 4;
  bit stray  = 0;
  bit rst_req = 1;
  bit req_i = 0, req_d = 0, req_w = 0;
  logic [15:0] ia = '0, da = '0, wa = '0, wd = '0;
  bit just_done = 0;
  int n_idone = 0, n_ddone = 0, n_ack = 0;

  // Reference model: op 0 = none, 1 = I block fill, 2 = D block fill, 3 = store
  int          op = 0;
  logic [15:0] m_base, m_data;
  int          t0, nrecv;
  logic [15:0] exp_q[$];

  // Memory device
  logic [15:0] mem_ref[int];
  int          due_q[$];
  logic [15:0] dat_q[$];

  function automatic logic [15:0] mem_rd(logic [15:0] a);
    if (!mem_ref.exists(int'(a))) mem_ref[int'(a)] = 16'($urandom);
    return mem_ref[int'(a)];
  endfunction

  task automatic chk16(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    bit v;
    int k;
    logic [15:0] e_addr, e_din, e_fd;
    logic e_en, e_wr, e_ack, e_ib, e_db, e_iwe, e_dwe, e_idn, e_ddn;
    @(negedge clk);
    cyc++;
    rst              = rst_req;
    bus.i_miss       = req_i;
    bus.i_miss_addr  = ia;
    bus.d_miss       = req_d;
    bus.d_miss_addr  = da;
    bus.d_wr_req     = req_w;
    bus.d_wr_addr    = wa;
    bus.d_wr_data    = wd;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      bus.mem_data_out   = dat_q.pop_front();
      bus.mem_data_valid = 1'b1;
    end else if (stray) begin
      bus.mem_data_out   = 16'($urandom);
      bus.mem_data_valid = 1'b1;
    end else begin
      bus.mem_data_out   = '0;
      bus.mem_data_valid = 1'b0;
    end
    v = bus.mem_data_valid;
    #1;
    e_addr = '0; e_din = '0; e_fd = '0;
    e_en = 0; e_wr = 0; e_ack = 0; e_ib = 0; e_db = 0;
    e_iwe = 0; e_dwe = 0; e_idn = 0; e_ddn = 0;
    case (op)
      1, 2: begin
        k    = cyc - t0;
        e_en = (k < BW);
        if (e_en) e_addr = m_base + 16'(2 * k);
        e_ib = (op == 1);
        e_db = (op == 2);
        if (v) begin
          e_iwe = (op == 1);
          e_dwe = (op == 2);
          e_idn = (op == 1) && (nrecv == BW - 1);
          e_ddn = (op == 2) && (nrecv == BW - 1);
          e_fd  = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
        end
        if (e_en) exp_q.push_back(mem_rd(e_addr));
      end
      3: begin
        e_en = 1; e_wr = 1; e_ack = 1; e_db = 1;
        e_addr = m_base;
        e_din  = m_data;
      end
      default: ;
    endcase
    chk1 ("mem_enable",   bus.mem_enable,  e_en);
    chk1 ("mem_wr",       bus.mem_wr,      e_wr);
    chk16("mem_addr",     bus.mem_addr,    e_addr);
    chk16("mem_data_in",  bus.mem_data_in, e_din);
    chk1 ("i_busy",       bus.i_busy,      e_ib);
    chk1 ("d_busy",       bus.d_busy,      e_db);
    chk1 ("i_fill_we",    bus.i_fill_we,   e_iwe);
    chk1 ("d_fill_we",    bus.d_fill_we,   e_dwe);
    chk1 ("i_fill_done",  bus.i_fill_done, e_idn);
    chk1 ("d_fill_done",  bus.d_fill_done, e_ddn);
    chk1 ("wr_ack",       bus.wr_ack,      e_ack);
    if (v && (op == 1 || op == 2)) begin
      chk16("fill_word", 16'(bus.fill_word), 16'(nrecv));
      chk16("fill_data", bus.fill_data, e_fd);
    end
    // memory reacts to whatever the DUT drives
    if (bus.mem_enable && bus.mem_wr) begin
      mem_ref[int'(bus.mem_addr)] = bus.mem_data_in;
    end else if (bus.mem_enable) begin
      due_q.push_back(cyc + lat);
      dat_q.push_back(mem_rd(bus.mem_addr));
    end
    if (rst_req) begin
      op = 0;
      nrecv = 0;
      exp_q.delete();
    end else begin
      case (op)
        0: begin
          if (req_i) begin
            op = 1; m_base = ia & MASK; t0 = cyc + 1; nrecv = 0;
          end else if (req_w) begin
            op = 3; m_base = wa; m_data = wd;
          end else if (req_d) begin
            op = 2; m_base = da & MASK; t0 = cyc + 1; nrecv = 0;
          end
        end
        1, 2: begin
          if (v) begin
            if (nrecv == BW - 1) begin
              chk16("fill_latency", 16'(cyc - t0), 16'(BW - 1 + lat));
              op = 0;
            end else begin
              nrecv++;
            end
          end
        end
        default: op = 0;
      endcase
    end
    // requesters drop their level the cycle after completion
    if (e_idn) begin req_i = 0; n_idone++; end
    if (e_ddn) begin req_d = 0; n_ddone++; end
    if (e_ack) begin req_w = 0; n_ack++; end
    just_done = e_idn || e_ddn || e_ack;
  endtask

  task automatic finish_op(int max_cyc);
    int n = 0;
    while (op != 0 && n < max_cyc) begin
      step();
      n++;
    end
    chk1("op_complete", op == 0, 1'b1);
  endtask

  task automatic run_op(int max_cyc);
    step();
    finish_op(max_cyc);
  endtask

  initial begin
    int base_i;
    bus.i_miss = 0; bus.d_miss = 0; bus.d_wr_req = 0;
    bus.i_miss_addr = '0; bus.d_miss_addr = '0; bus.d_wr_addr = '0; bus.d_wr_data = '0;
    bus.mem_data_out = '0; bus.mem_data_valid = 0;

    // reset; outputs checked idle every cycle
    rst_req = 1;
    repeat (2) step();
    rst_req = 0;
    step();

    // single I fill at 0x1236, L = 4
    lat = 4; ia = 16'h1236; req_i = 1;
    run_op(40);
    chk16("t1_idone_count", 16'(n_idone), 16'd1);
    chk16("t1_ddone_count", 16'(n_ddone), 16'd0);
    step();

    // simultaneous requests: I fill, then store, then D fill
    ia = 16'h5558; da = 16'h4000; wa = 16'h2002; wd = 16'hBEEF;
    req_i = 1; req_d = 1; req_w = 1;
    run_op(40);
    run_op(5);
    chk16("t2_ack_count", 16'(n_ack), 16'd1);
    chk16("t2_store_mem", mem_ref[int'(16'h2002)], 16'hBEEF);
    run_op(40);
    chk16("t2_idone_count", 16'(n_idone), 16'd2);
    chk16("t2_ddone_count", 16'(n_ddone), 16'd1);
    step();

    // D fill with i_miss rising at word 3
    lat = $urandom_range(2, 6);
    da = 16'($urandom); req_d = 1;
    step();
    for (int n = 0; n < 40 && op != 0 && nrecv < 3; n++) step();
    ia = 16'($urandom); req_i = 1;
    finish_op(40);
    chk16("t3_ddone_count", 16'(n_ddone), 16'd2);
    run_op(40);
    chk16("t3_idone_count", 16'(n_idone), 16'd3);
    step();

    // reset during issue cycle 5 of an I fill; late data must be ignored
    lat = 4; ia = 16'($urandom); req_i = 1;
    step();
    for (int n = 0; n < 20 && cyc < t0 + 4; n++) step();
    rst_req = 1; req_i = 0;
    step();
    rst_req = 0;
    repeat (lat + 3) step();
    chk16("t4_idone_count", 16'(n_idone), 16'd3);

    // stray valids while idle
    stray = 1;
    repeat (5) step();
    stray = 0;
    chk16("t5_stray_idone", 16'(n_idone), 16'd3);

    // requester drops i_miss mid-fill
    base_i = n_idone;
    ia = 16'($urandom); req_i = 1;
    step();
    repeat (3) step();
    req_i = 0;
    finish_op(40);
    chk16("t6_drop_idone", 16'(n_idone), 16'(base_i + 1));
    step();

    // random traffic
    for (int i = 0; i < 500; i++) begin
      if (op == 0 && due_q.size() == 0 && $urandom_range(0, 9) == 0) lat = $urandom_range(1, 6);
      if (!just_done) begin
        if (!req_i && $urandom_range(0, 5) == 0) begin ia = 16'($urandom); req_i = 1; end
        if (!req_d && $urandom_range(0, 5) == 0) begin da = 16'($urandom); req_d = 1; end
        if (!req_w && $urandom_range(0, 7) == 0) begin
          wa = 16'($urandom) & 16'hFFFE; wd = 16'($urandom); req_w = 1;
        end
      end
      stray = (op == 0) && ($urandom_range(0, 3) == 0);
      step();
    end
    stray = 0; req_i = 0; req_d = 0; req_w = 0;
    finish_op(60);
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "global timeout");
  end
endmodule
